dense_mac_layer1_4: RTL and testbench

Serial multiply-accumulate engine for dense layer 1_4, directly downstream of the layer 1_4 weight loader. Once the loader's `done` is high, it takes the loader's flat weight bus and a flat input-activation vector. It computes OUT_SIZE dot products of length IN_SIZE using a single signed MAC, one product per cycle. It presents the results as a flat accumulator bus for the next layer stage.

---
 rtl/dense_mac_layer1_4.sv | 120 ++++++++++++
 tb/tb_dense_mac_layer1_4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dense_mac_layer1_4.sv
// Serial signed multiply-accumulate engine for dense layer 1_4: one product per cycle, OUT_SIZE dot products of length IN_SIZE.
// Optional macro DENSE_RELU_EN clamps negative results to zero when they are stored.
module dense_mac_layer1_4 #(
   parameter int IN_SIZE       = 1152,
   parameter int OUT_SIZE      = 8,
   parameter int W             = 8,
   parameter int ACC_W         = 32,
   parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [TOTAL_WEIGHTS*W-1:0]  weights_in,
   input  logic [IN_SIZE*W-1:0]        act_in,
   output logic [OUT_SIZE*ACC_W-1:0]   data_out,
   output logic                        busy,
   output logic                        done,
   output logic [1:0]                  state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_STORE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int I_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam int O_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int WB_W = $clog2(TOTAL_WEIGHTS * W);
   localparam int AB_W = $clog2(IN_SIZE * W);
   localparam logic [I_W-1:0] I_LAST = I_W'(IN_SIZE - 1);
   localparam logic [O_W-1:0] O_LAST = O_W'(OUT_SIZE - 1);

   state_t state_q, state_d;
   logic [I_W-1:0]           i_q;
   logic [O_W-1:0]           o_q;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  store_val;
   logic [WB_W-1:0]          w_lsb;
   logic [AB_W-1:0]          a_lsb;
   logic signed [W-1:0]      w_cur;
   logic signed [W-1:0]      x_cur;
   logic signed [2*W-1:0]    prod;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_MAC;
         S_MAC:   if (i_q == I_LAST) state_d = S_STORE;
         S_STORE: state_d = (o_q == O_LAST) ? S_DONE : S_MAC;
         S_DONE:  if (start) state_d = S_MAC;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy      = (state_q == S_MAC) || (state_q == S_STORE);
      done      = (state_q == S_DONE);
      state_dbg = state_q;
   end

   // Operand selection: weights are neuron-major, so w[o][i] sits at (o*IN_SIZE+i)*W.
   always_comb begin
      w_lsb    = WB_W'((int'(o_q) * IN_SIZE + int'(i_q)) * W);
      a_lsb    = AB_W'(int'(i_q) * W);
      w_cur    = weights_in[w_lsb +: W];
      x_cur    = act_in[a_lsb +: W];
      prod     = w_cur * x_cur;
      acc_next = acc + ACC_W'(prod);
`ifdef DENSE_RELU_EN
      store_val = acc[ACC_W-1] ? '0 : acc;
`else
      store_val = acc;
`endif
   end

   // Datapath: counters, accumulator and result slots
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         i_q      <= '0;
         o_q      <= '0;
         data_out <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  acc <= '0;
                  i_q <= '0;
                  o_q <= '0;
               end
            end
            S_MAC: begin
               acc <= acc_next;
               if (i_q != I_LAST) i_q <= i_q + 1'b1;
            end
            S_STORE: begin
               for (int s = 0; s < OUT_SIZE; s++) begin
                  if (o_q == O_W'(s)) data_out[s*ACC_W +: ACC_W] <= store_val;
               end
               acc <= '0;
               i_q <= '0;
               if (o_q != O_LAST) o_q <= o_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_mac_layer1_4.sv
// Self-checking bench for dense_mac_layer1_4 with a small configuration (4 inputs, 2 neurons).
module tb_dense_mac_layer1_4;
   localparam int IN_SIZE  = 4;
   localparam int OUT_SIZE = 2;
   localparam int W        = 8;
   localparam int ACC_W    = 32;
   localparam int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE;
   localparam int RUN_LAT  = OUT_SIZE * (IN_SIZE + 1);

   logic                        clk;
   logic                        rst;
   logic                        start;
   logic [TOTAL_WEIGHTS*W-1:0]  weights_in;
   logic [IN_SIZE*W-1:0]        act_in;
   logic [OUT_SIZE*ACC_W-1:0]   data_out;
   logic                        busy;
   logic                        done;
   logic [1:0]                  state_dbg;

   int xv [IN_SIZE];
   int wv [OUT_SIZE][IN_SIZE];
   logic [ACC_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   dense_mac_layer1_4 #(
      .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .ACC_W(ACC_W), .TOTAL_WEIGHTS(TOTAL_WEIGHTS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .weights_in(weights_in), .act_in(act_in),
      .data_out(data_out), .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
   endtask

   task automatic load_inputs();
      for (int i = 0; i < IN_SIZE; i++) begin
         act_in[i*W +: W] = xv[i][W-1:0];
         for (int o = 0; o < OUT_SIZE; o++) weights_in[(o*IN_SIZE+i)*W +: W] = wv[o][i][W-1:0];
      end
   endtask

   // Reference dot products pushed when a run is launched.
   task automatic push_expected();
      int sum;
      for (int o = 0; o < OUT_SIZE; o++) begin
         sum = 0;
         for (int i = 0; i < IN_SIZE; i++) sum += xv[i] * wv[o][i];
`ifdef DENSE_RELU_EN
         if (sum < 0) sum = 0;
`endif
         exp_q.push_back(sum[ACC_W-1:0]);
      end
   endtask

   task automatic pulse_start();
      push_expected();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat, output int busy_cyc);
      lat = lat0;
      busy_cyc = 0;
      while (!done && lat < 200) begin
         if (busy) busy_cyc++;
         tick();
         lat++;
      end
      check("done_within_bound", done, 1'b1);
   endtask

   task automatic sb_results(input string tag);
      logic [ACC_W-1:0] e;
      check({tag, "_sb_depth"}, exp_q.size() >= OUT_SIZE, 1'b1);
      for (int o = 0; o < OUT_SIZE; o++) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_y%0d", tag, o), data_out[o*ACC_W +: ACC_W], e);
         end
      end
   endtask

   initial begin
      int lat, bc, ndone, last_c;
      rst = 1'b1; start = 1'b0; weights_in = '0; act_in = '0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      check("rst_state", state_dbg, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      for (int o = 0; o < OUT_SIZE; o++) check($sformatf("rst_y%0d", o), data_out[o*ACC_W +: ACC_W], '0);

      // Basic
      xv = '{1, 2, 3, 4};
      wv[0] = '{1, 1, 1, 1};
      wv[1] = '{2, 0, -1, 1};
      load_inputs();
      pulse_start();
      wait_done(0, lat, bc);
      check("basic_latency", lat, RUN_LAT);
      check("basic_busy_cycles", bc, RUN_LAT);
      check("basic_busy_low_at_done", busy, 1'b0);
      sb_results("basic");
      repeat (3) tick();
      check("done_level_held", done, 1'b1);

      // Extremes
      for (int i = 0; i < IN_SIZE; i++) begin
         xv[i] = -128;
         for (int o = 0; o < OUT_SIZE; o++) wv[o][i] = -128;
      end
      load_inputs();
      pulse_start();
      wait_done(0, lat, bc);
      sb_results("ext_neg_neg");
      for (int i = 0; i < IN_SIZE; i++) xv[i] = 127;
      load_inputs();
      pulse_start();
      wait_done(0, lat, bc);
      sb_results("ext_pos_neg");

      // Random operands
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < IN_SIZE; i++) begin
            xv[i] = $urandom_range(255) - 128;
            for (int o = 0; o < OUT_SIZE; o++) wv[o][i] = $urandom_range(255) - 128;
         end
         load_inputs();
         pulse_start();
         wait_done(0, lat, bc);
         check("rand_latency", lat, RUN_LAT);
         sb_results("rand");
      end

      // Reset during neuron 1 accumulation
      xv = '{1, 2, 3, 4};
      wv[0] = '{1, 1, 1, 1};
      wv[1] = '{2, 0, -1, 1};
      load_inputs();
      pulse_start();
      repeat (6) tick();
      check("mid_busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      for (int o = 0; o < OUT_SIZE; o++) check($sformatf("midrst_y%0d", o), data_out[o*ACC_W +: ACC_W], '0);
      pulse_start();
      wait_done(0, lat, bc);
      check("midrst_rerun_latency", lat, RUN_LAT);
      sb_results("midrst_rerun");

      // Start ignored while busy
      pulse_start();
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(3, lat, bc);
      check("ignored_start_latency", lat, RUN_LAT);
      sb_results("ignored_start");
      check("ignored_start_sb_empty", exp_q.size(), 0);

      // Restart from DONE with new activations; slots update one at a time
      xv = '{0, 0, 0, 1};
      load_inputs();
      pulse_start();
      for (int c = 0; c <= RUN_LAT; c++) begin
         check($sformatf("restart_y0_c%0d", c), data_out[0 +: ACC_W], (c >= IN_SIZE + 1) ? 32'd1 : 32'd10);
         check($sformatf("restart_y1_c%0d", c), data_out[ACC_W +: ACC_W], (c >= RUN_LAT) ? 32'd1 : 32'd3);
         if (c < RUN_LAT) tick();
      end
      check("restart_done", done, 1'b1);
      sb_results("restart");

      // Back-to-back runs with start held high
      for (int r = 0; r < 3; r++) push_expected();
      ndone = 0;
      last_c = -1;
      start = 1'b1;
      for (int c = 1; c <= 3 * (RUN_LAT + 1); c++) begin
         tick();
         if (done) begin
            ndone++;
            if (last_c >= 0) check("b2b_done_gap", c - last_c, RUN_LAT + 1);
            last_c = c;
            sb_results("b2b");
         end
      end
      start = 1'b0;
      check("b2b_done_count", ndone, 3);
      check("b2b_sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
